regfile_multiport: RTL
======================

Name: regfile_multiport

Overview:
Parametrised, clocked general-purpose register file for the datapath. It has a configurable number of synchronous read ports and two write ports with fixed priority. Same-cycle write-to-read forwarding is optional, and register 0 can optionally be hardwired to zero. It replaces the earlier level-sensitive 32x32 file as the register stage feeding the ALU operand muxes.

Parameters:
DATA_W, 32, bits per register
DEPTH, 32, number of registers (power of two, >= 2)
ADDR_W, 5, address width, equals log2(DEPTH)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a read returns data written in the same cycle to the same address

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wr0_en  in  1  write port 0 enable (high priority)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (low priority)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k in slice k
rd_data  out  NUM_RD*DATA_W  packed registered read data, port k in slice k
rd_valid  out  NUM_RD  high the cycle after an accepted read
wr_conflict  out  1  registered pulse: both write enables high to the same address last cycle

Behaviour:
- Single clock, synchronous active-high reset. On reset:
  - all DEPTH registers = 0
  - rd_data = 0, rd_valid = 0, wr_conflict = 0
  - writes and reads presented in the reset cycle are discarded
- Writes commit at the rising edge; the new value is visible in the array from the next cycle.
- Write collision (wr0_en & wr1_en & wr0_addr == wr1_addr):
  - wr0_data is stored and wr1 is dropped
  - wr_conflict = 1 for exactly one cycle after
- Different-address dual writes both commit.
- ZERO_REG = 1:
  - writes to address 0 are ignored on both ports
  - reads of address 0 return 0
  - a collision at address 0 still raises wr_conflict
- Reads have 1-cycle latency:
  - if rd_en[k] is high at edge N, rd_data slice k and rd_valid[k] update at edge N
  - they are visible during cycle N+1
  - if rd_en[k] is low, slice k holds its previous value and rd_valid[k] = 0
- BYPASS = 1, for a read address matching a write address in the same cycle:
  - returned data = the value being written, with wr0 winning over wr1
  - address 0 under ZERO_REG still returns 0
- BYPASS = 0: a same-cycle read returns the pre-write array contents.
- Multiple read ports may address the same register; all return identical data.
- Out-of-range addresses are impossible because DEPTH = 2^ADDR_W.
- No state machine beyond the array, output registers and the conflict flag. There are no stalls and no backpressure: every enabled read is served.
- Reset mid-operation: reset overrides any write or read in that cycle. Pending rd_valid clears on the same edge.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W, DEPTH, ADDR_W
  - REG_ZERO_ADDR constant
  - a function returning the packed-slice index for a port
- One natural sub-module: regfile_read_port.
  - One instance per read port, built with a generate loop.
  - It performs address decode, the bypass/zero-mux and the output register for one port.
  - Inputs: the array, both write-port signals, its rd_en/rd_addr.
- Storage and write-priority logic stay in the top module.

Test Plan:
1. Reset then read all 32 addresses on both ports: every rd_data = 0x00000000, rd_valid high one cycle after each rd_en.
2. Write wr0 addr 5 = 0xDEADBEEF, next cycle read port0 addr 5: rd_data0 = 0xDEADBEEF one cycle later, rd_valid[0] = 1.
3. Same cycle: wr0 addr 7 = 0x11111111, wr1 addr 7 = 0x22222222, read port1 addr 7 (BYPASS = 1): rd_data1 = 0x11111111, wr_conflict = 1 one cycle later; subsequent read = 0x11111111.
4. ZERO_REG = 1: wr0 addr 0 = 0xFFFFFFFF, then read addr 0 on both ports: both return 0; with ZERO_REG = 0 a rebuilt DUT returns 0xFFFFFFFF.
5. BYPASS = 0 build: reg 9 holds 0xA5A5A5A5; same cycle write 0x5A5A5A5A to 9 and read 9: returns 0xA5A5A5A5, next read returns 0x5A5A5A5A.
6. Reset asserted in a cycle with wr0 addr 3 = 0x1234 and rd_en = 2'b11: after the edge rd_valid = 0 and rd_data = 0; a later read of addr 3 returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multiport register file.
// Pure declarations: no logic, no latency, no flow control.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int REG_ZERO_ADDR = 0;

  // Low bit of port k's slice in a packed multi-port bus of given lane width.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: address decode, same-cycle bypass / zero mux, output register.
// Latency 1 cycle; always accepts, no backpressure.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  input  logic                    wr0_en,
  input  logic [ADDR_W-1:0]       wr0_addr,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [ADDR_W-1:0]       wr1_addr,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid
);

  logic [DATA_W-1:0] next_data;

  always_comb begin
    next_data = mem_flat[int'(rd_addr) * DATA_W +: DATA_W];
    if (BYPASS != 0) begin
      // wr1 first so a matching wr0 overrides it
      if (wr1_en && (wr1_addr == rd_addr)) next_data = wr1_data;
      if (wr0_en && (wr0_addr == rd_addr)) next_data = wr0_data;
    end
    if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO_ADDR))) next_data = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= next_data;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register file with NUM_RD synchronous read ports and two prioritised write ports.
// Reads return one cycle after rd_en; writes commit at the edge; no backpressure.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     wr_conflict
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         same_addr;
  logic                         wr0_ok;
  logic                         wr1_ok;

  assign same_addr = wr0_en && wr1_en && (wr0_addr == wr1_addr);
  assign wr0_ok = wr0_en &&
                  !((ZERO_REG != 0) && (wr0_addr == ADDR_W'(REG_ZERO_ADDR)));
  // On a collision the high-priority port owns the register; wr1 is dropped.
  assign wr1_ok = wr1_en && !same_addr &&
                  !((ZERO_REG != 0) && (wr1_addr == ADDR_W'(REG_ZERO_ADDR)));

  always_ff @(posedge clk) begin
    if (reset) begin
      mem         <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      wr_conflict <= same_addr;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .clk     (clk),
      .reset   (reset),
      .mem_flat(mem),
      .wr0_en  (wr0_en),
      .wr0_addr(wr0_addr),
      .wr0_data(wr0_data),
      .wr1_en  (wr1_en),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .rd_en   (rd_en[k]),
      .rd_addr (rd_addr[slice_lo(k, ADDR_W) +: ADDR_W]),
      .rd_data (rd_data[slice_lo(k, DATA_W) +: DATA_W]),
      .rd_valid(rd_valid[k])
    );
  end

endmodule
